// File: rtl/rect_motion_fsm.sv
// rect_motion_fsm: follows the mouse, drops the rectangle on click and runs per-frame gravity/bounce until it rests on the floor.
module rect_motion_fsm #(
  parameter int VISIBLE_HEIGHT = 600,
  parameter int RECT_HEIGHT = 64,
  parameter int FRAC = 4,
  parameter int ACCEL = 16,
  parameter int STOP_VEL = 2,
  parameter int MAX_BOUNCES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        mouse_left,
  input  logic [11:0] mouse_x_position,
  input  logic [11:0] mouse_y_position,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [1:0]  state,
  output logic        busy
);
  localparam int FLOOR = VISIBLE_HEIGHT - RECT_HEIGHT;
  localparam logic [1:0] FOLLOW = 2'd0, FALL = 2'd1, REST = 2'd2;
  logic vsync_d, left_d, tick, click;
  logic [1:0] next_state;
  logic signed [15:0] vel, vel_nxt, v1, dv, half, vb, vb_abs;
  logic signed [16:0] vsum;
  logic signed [12:0] y1;
  logic [11:0] x_nxt, y_nxt;
  logic [3:0] bounce_cnt, cnt_nxt;
  logic hit, neg, stop;
  assign tick = vsync & ~vsync_d;
  assign click = mouse_left & ~left_d;
  // Physics candidate for the next frame; only committed on a tick in FALL.
  always_comb begin
    vsum = 17'(vel) + 17'(ACCEL);
    v1 = vsum > 17'sd32767 ? 16'sh7fff : vsum < -17'sd32768 ? 16'sh8000 : vsum[15:0];
    dv = v1 >>> FRAC;
    y1 = $signed({1'b0, ypos}) + $signed(dv[12:0]);
    neg = y1 < 13'sd0;
    hit = y1 >= $signed(13'(FLOOR));
    half = v1 >>> 1;
    vb = -half;
    vb_abs = vb < 16'sd0 ? -vb : vb;
    stop = (vb_abs < $signed(16'(STOP_VEL << FRAC))) || (bounce_cnt + 4'd1 == 4'(MAX_BOUNCES));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FOLLOW;
      busy <= 1'b0;
    end else begin
      state <= next_state;
      busy <= next_state == FALL;
    end
  end
  always_comb begin
    next_state = state == FOLLOW ? (click ? FALL : FOLLOW) :
                 state == FALL   ? ((tick && !neg && hit && stop) ? REST : FALL) :
                 state == REST   ? (click ? FOLLOW : REST) : FOLLOW;
  end
  always_comb begin
    x_nxt = xpos;
    y_nxt = ypos;
    vel_nxt = vel;
    cnt_nxt = bounce_cnt;
    if (state == FOLLOW) begin
      if (click) begin
        vel_nxt = 16'sd0;
        cnt_nxt = 4'd0;
      end else begin
        x_nxt = mouse_x_position;
        y_nxt = mouse_y_position > 12'(FLOOR) ? 12'(FLOOR) : mouse_y_position;
      end
    end else if (state == FALL && tick) begin
      if (neg) begin
        y_nxt = 12'd0;
        vel_nxt = 16'sd0;
      end else if (hit) begin
        y_nxt = 12'(FLOOR);
        cnt_nxt = bounce_cnt + 4'd1;
        vel_nxt = stop ? 16'sd0 : vb;
      end else begin
        y_nxt = y1[11:0];
        vel_nxt = v1;
      end
    end else if (state == REST) begin
      y_nxt = 12'(FLOOR);
      vel_nxt = 16'sd0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d <= 1'b0;
      left_d <= 1'b0;
      xpos <= 12'd0;
      ypos <= 12'd0;
      vel <= 16'sd0;
      bounce_cnt <= 4'd0;
    end else begin
      vsync_d <= vsync;
      left_d <= mouse_left;
      xpos <= x_nxt;
      ypos <= y_nxt;
      vel <= vel_nxt;
      bounce_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_rect_motion_fsm.sv
// tb_rect_motion_fsm: directed scenarios for rect_motion_fsm with hand-computed expectations.
module tb_rect_motion_fsm;
  logic clk = 1'b0, rst = 1'b1, vsync = 1'b0, mouse_left = 1'b0;
  logic [11:0] mouse_x_position = '0, mouse_y_position = '0;
  logic [11:0] xpos, ypos;
  logic [1:0] state;
  logic busy;
  int n_cmp = 0, n_err = 0;

  rect_motion_fsm dut (
    .clk(clk), .rst(rst), .vsync(vsync), .mouse_left(mouse_left),
    .mouse_x_position(mouse_x_position), .mouse_y_position(mouse_y_position),
    .xpos(xpos), .ypos(ypos), .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    vsync = 1'b1;
    step(1);
    vsync = 1'b0;
    step(1);
  endtask

  task automatic click_pulse();
    mouse_left = 1'b1;
    step(1);
    mouse_left = 1'b0;
    step(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vsync = 1'b0;
    mouse_left = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mouse_x_position = 12'd77;
    mouse_y_position = 12'd0;
    do_reset();
    n_cmp++; if (state !== 2'd0 || busy !== 1'b0 || xpos !== 12'd0 || ypos !== 12'd0) begin n_err++; $display("FAIL reset_init: state=%0d busy=%0d x=%0d y=%0d want 0 0 0 0", state, busy, xpos, ypos); end
    step(1);
    click_pulse();
    repeat (24) frame();
    n_cmp++; if (ypos !== 12'd300 || state !== 2'd1) begin n_err++; $display("FAIL pre_reset_fall: y=%0d state=%0d want 300 1", ypos, state); end
    rst = 1'b1;
    step(1);
    n_cmp++; if (state !== 2'd0 || busy !== 1'b0 || xpos !== 12'd0 || ypos !== 12'd0) begin n_err++; $display("FAIL reset_mid_fall: state=%0d busy=%0d x=%0d y=%0d want 0 0 0 0", state, busy, xpos, ypos); end
    n_cmp++; if (dut.vel !== 16'sd0 || dut.bounce_cnt !== 4'd0) begin n_err++; $display("FAIL reset_regs: vel=%0d cnt=%0d want 0 0", dut.vel, dut.bounce_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_follow();
    do_reset();
    mouse_x_position = 12'd100;
    mouse_y_position = 12'd700;
    step(1);
    n_cmp++; if (xpos !== 12'd100 || ypos !== 12'd536) begin n_err++; $display("FAIL follow_clamp: x=%0d y=%0d want 100 536", xpos, ypos); end
    mouse_x_position = 12'd20;
    mouse_y_position = 12'd300;
    step(1);
    n_cmp++; if (xpos !== 12'd20 || ypos !== 12'd300 || state !== 2'd0) begin n_err++; $display("FAIL follow_track: x=%0d y=%0d state=%0d want 20 300 0", xpos, ypos, state); end
    mouse_y_position = 12'd536;
    step(1);
    n_cmp++; if (ypos !== 12'd536) begin n_err++; $display("FAIL follow_floor: y=%0d want 536", ypos); end
  endtask

  task automatic test_drop_near_floor();
    do_reset();
    mouse_x_position = 12'd50;
    mouse_y_position = 12'd534;
    step(1);
    mouse_left = 1'b1;
    mouse_x_position = 12'd999;
    step(1);
    n_cmp++; if (state !== 2'd1 || busy !== 1'b1 || ypos !== 12'd534 || xpos !== 12'd50) begin n_err++; $display("FAIL drop_enter: state=%0d busy=%0d x=%0d y=%0d want 1 1 50 534", state, busy, xpos, ypos); end
    mouse_left = 1'b0;
    step(1);
    frame();
    n_cmp++; if (ypos !== 12'd535 || dut.vel !== 16'sd16 || xpos !== 12'd50) begin n_err++; $display("FAIL drop_tick1: y=%0d vel=%0d x=%0d want 535 16 50", ypos, dut.vel, xpos); end
    frame();
    n_cmp++; if (ypos !== 12'd536 || state !== 2'd2 || busy !== 1'b0 || dut.vel !== 16'sd0) begin n_err++; $display("FAIL drop_rest: y=%0d state=%0d busy=%0d vel=%0d want 536 2 0 0", ypos, state, busy, dut.vel); end
    frame();
    n_cmp++; if (ypos !== 12'd536 || state !== 2'd2 || xpos !== 12'd50) begin n_err++; $display("FAIL rest_hold: y=%0d state=%0d x=%0d want 536 2 50", ypos, state, xpos); end
    mouse_y_position = 12'd40;
    mouse_left = 1'b1;
    step(1);
    n_cmp++; if (state !== 2'd0 || busy !== 1'b0) begin n_err++; $display("FAIL rest_pickup: state=%0d busy=%0d want 0 0", state, busy); end
    mouse_left = 1'b0;
    step(1);
    n_cmp++; if (xpos !== 12'd999 || ypos !== 12'd40) begin n_err++; $display("FAIL pickup_track: x=%0d y=%0d want 999 40", xpos, ypos); end
  endtask

  task automatic test_drop_from_top();
    do_reset();
    mouse_x_position = 12'd10;
    mouse_y_position = 12'd0;
    step(1);
    click_pulse();
    for (int n = 1; n <= 32; n++) begin
      frame();
      n_cmp++; if (ypos !== 12'(n * (n + 1) / 2)) begin n_err++; $display("FAIL fall_tick%0d: y=%0d want %0d", n, ypos, n * (n + 1) / 2); end
    end
    frame();
    n_cmp++; if (ypos !== 12'd536 || dut.vel !== -16'sd264 || dut.bounce_cnt !== 4'd1 || state !== 2'd1 || busy !== 1'b1) begin n_err++; $display("FAIL bounce1: y=%0d vel=%0d cnt=%0d state=%0d busy=%0d want 536 -264 1 1 1", ypos, dut.vel, dut.bounce_cnt, state, busy); end
    frame();
    n_cmp++; if (ypos !== 12'd520 || dut.vel !== -16'sd248) begin n_err++; $display("FAIL rebound: y=%0d vel=%0d want 520 -248", ypos, dut.vel); end
    step(3);
    n_cmp++; if (ypos !== 12'd520 || dut.vel !== -16'sd248) begin n_err++; $display("FAIL no_tick_hold: y=%0d vel=%0d want 520 -248", ypos, dut.vel); end
  endtask

  task automatic test_held_button();
    do_reset();
    mouse_x_position = 12'd30;
    mouse_y_position = 12'd100;
    step(1);
    mouse_left = 1'b1;
    step(1);
    repeat (10) frame();
    n_cmp++; if (state !== 2'd1 || ypos !== 12'd155 || xpos !== 12'd30) begin n_err++; $display("FAIL held_button: state=%0d x=%0d y=%0d want 1 30 155", state, xpos, ypos); end
    mouse_left = 1'b0;
    step(1);
    click_pulse();
    n_cmp++; if (state !== 2'd1 || busy !== 1'b1 || ypos !== 12'd155) begin n_err++; $display("FAIL fall_click_ignored: state=%0d busy=%0d y=%0d want 1 1 155", state, busy, ypos); end
  endtask

  task automatic test_click_tick_same();
    do_reset();
    mouse_x_position = 12'd40;
    mouse_y_position = 12'd200;
    step(1);
    vsync = 1'b1;
    mouse_left = 1'b1;
    step(1);
    n_cmp++; if (state !== 2'd1 || ypos !== 12'd200) begin n_err++; $display("FAIL click_tick_enter: state=%0d y=%0d want 1 200", state, ypos); end
    vsync = 1'b0;
    mouse_left = 1'b0;
    step(2);
    n_cmp++; if (ypos !== 12'd200) begin n_err++; $display("FAIL click_tick_nomove: y=%0d want 200", ypos); end
    frame();
    n_cmp++; if (ypos !== 12'd201 || dut.vel !== 16'sd16) begin n_err++; $display("FAIL click_tick_next: y=%0d vel=%0d want 201 16", ypos, dut.vel); end
  endtask

  initial begin
    test_reset();
    test_follow();
    test_drop_near_floor();
    test_drop_from_top();
    test_held_button();
    test_click_tick_same();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
